// File: rtl/wash_sequencer_if.sv
// Front-panel controls and actuator/display outputs of the wash program sequencer.
// The panel side drives the controls and the sequencer drives everything else.
interface wash_sequencer_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic       lid_open;
    logic [1:0] mode;
    logic [2:0] phase;
    logic [7:0] remain;
    logic       busy;
    logic       lock;
    logic       valve_in;
    logic       valve_out;
    logic [1:0] motor;
    logic       fault;
    logic       done_pulse;
    logic       alarm;

    modport master (
        output start, pause, abort, lid_open, mode,
        input  phase, remain, busy, lock, valve_in, valve_out, motor, fault, done_pulse, alarm
    );

    modport slave (
        input  start, pause, abort, lid_open, mode,
        output phase, remain, busy, lock, valve_in, valve_out, motor, fault, done_pulse, alarm
    );
endinterface

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: FILL/WASH/RINSE/SPIN with a seconds countdown,
// pause, lid-open fault, abort and an end-of-program alarm. All outputs are registered.
module wash_sequencer #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int ALARM_SEC     = 3
) (
    input logic             clk,
    input logic             rst,
    wash_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        WASH   = 3'd2,
        RINSE  = 3'd3,
        SPIN   = 3'd4,
        PAUSED = 3'd5,
        DONE   = 3'd6
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       lock;
        logic       valve_in;
        logic       valve_out;
        logic [1:0] motor;
    } act_t;

    localparam int ALARM_CYC = ALARM_SEC * TICKS_PER_SEC;
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int AW = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;

    function automatic logic [7:0] dur(input logic [1:0] m, input state_t p);
        logic [7:0] d;
        d = 8'd0;
        case (m)
            2'd0: case (p) FILL: d = 8'd5;  WASH: d = 8'd20; RINSE: d = 8'd10; SPIN: d = 8'd10; default: d = 8'd0; endcase
            2'd1: case (p) FILL: d = 8'd10; WASH: d = 8'd40; RINSE: d = 8'd20; SPIN: d = 8'd20; default: d = 8'd0; endcase
            2'd2: case (p) FILL: d = 8'd10; WASH: d = 8'd60; RINSE: d = 8'd30; SPIN: d = 8'd30; default: d = 8'd0; endcase
            default: case (p) SPIN: d = 8'd20; default: d = 8'd0; endcase
        endcase
        return d;
    endfunction

    function automatic logic [7:0] total(input logic [1:0] m);
        return dur(m, FILL) + dur(m, WASH) + dur(m, RINSE) + dur(m, SPIN);
    endfunction

    // First phase at or after 'from' with a nonzero duration; DONE when none is left.
    function automatic state_t next_run(input logic [1:0] m, input logic [2:0] from);
        state_t n;
        n = DONE;
        if (from <= 3'd4 && dur(m, SPIN)  != 8'd0) n = SPIN;
        if (from <= 3'd3 && dur(m, RINSE) != 8'd0) n = RINSE;
        if (from <= 3'd2 && dur(m, WASH)  != 8'd0) n = WASH;
        if (from <= 3'd1 && dur(m, FILL)  != 8'd0) n = FILL;
        return n;
    endfunction

    state_t          state, state_d, saved, saved_d, nxt;
    logic [1:0]      mode_q, mode_d;
    logic [PW-1:0]   presc, presc_d;
    logic [7:0]      pcnt, pcnt_d, remain, remain_d;
    logic [AW-1:0]   alarm_cnt, alarm_cnt_d;
    logic            fault, fault_d, pulse_d, done_q, alarm_q;
    act_t            act, act_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d     = state;
        saved_d     = saved;
        mode_d      = mode_q;
        presc_d     = presc;
        pcnt_d      = pcnt;
        remain_d    = remain;
        alarm_cnt_d = alarm_cnt;
        fault_d     = fault;
        pulse_d     = 1'b0;
        nxt         = DONE;

        if (bus.abort) begin
            state_d     = IDLE;
            saved_d     = IDLE;
            mode_d      = 2'd0;
            presc_d     = '0;
            pcnt_d      = 8'd0;
            remain_d    = 8'd0;
            alarm_cnt_d = '0;
            fault_d     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.lid_open) begin
                        mode_d   = bus.mode;
                        nxt      = next_run(bus.mode, 3'd1);
                        state_d  = nxt;
                        pcnt_d   = dur(bus.mode, nxt);
                        remain_d = total(bus.mode);
                        presc_d  = '0;
                    end
                end
                FILL, WASH, RINSE, SPIN: begin
                    // Pause or lid entry swallows a coinciding tick; the prescaler holds.
                    if (bus.lid_open) begin
                        saved_d = state;
                        state_d = PAUSED;
                        fault_d = 1'b1;
                    end else if (bus.pause) begin
                        saved_d = state;
                        state_d = PAUSED;
                        fault_d = 1'b0;
                    end else if (presc == PW'(TICKS_PER_SEC - 1)) begin
                        presc_d  = '0;
                        remain_d = remain - 8'd1;
                        if (pcnt == 8'd1) begin
                            nxt     = next_run(mode_q, 3'(state) + 3'd1);
                            state_d = nxt;
                            pcnt_d  = dur(mode_q, nxt);
                            if (nxt == DONE) begin
                                alarm_cnt_d = '0;
                                pulse_d     = 1'b1;
                            end
                        end else begin
                            pcnt_d = pcnt - 8'd1;
                        end
                    end else begin
                        presc_d = presc + PW'(1);
                    end
                end
                PAUSED: begin
                    if (bus.lid_open) begin
                        fault_d = 1'b1;
                    end else if (bus.start) begin
                        state_d = saved;
                        fault_d = 1'b0;
                    end
                end
                DONE: begin
                    if (bus.start || alarm_cnt == AW'(ALARM_CYC - 1)) begin
                        state_d     = IDLE;
                        alarm_cnt_d = '0;
                    end else begin
                        alarm_cnt_d = alarm_cnt + AW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Actuator outputs are decoded from the next state so they register alongside it.
    always_comb begin
        act_d = '0;
        case (state_d)
            FILL:   begin act_d.busy = 1'b1; act_d.lock = 1'b1; act_d.valve_in = 1'b1; end
            WASH:   begin act_d.busy = 1'b1; act_d.lock = 1'b1; act_d.motor = 2'd1; end
            RINSE:  begin act_d.busy = 1'b1; act_d.lock = 1'b1; act_d.valve_in = 1'b1; act_d.motor = 2'd1; end
            SPIN:   begin act_d.busy = 1'b1; act_d.lock = 1'b1; act_d.valve_out = 1'b1; act_d.motor = 2'd2; end
            PAUSED: begin act_d.busy = 1'b1; act_d.lock = !fault_d; end
            default: act_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            saved     <= IDLE;
            mode_q    <= 2'd0;
            presc     <= '0;
            pcnt      <= 8'd0;
            remain    <= 8'd0;
            alarm_cnt <= '0;
            fault     <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
            act       <= '0;
        end else begin
            state     <= state_d;
            saved     <= saved_d;
            mode_q    <= mode_d;
            presc     <= presc_d;
            pcnt      <= pcnt_d;
            remain    <= remain_d;
            alarm_cnt <= alarm_cnt_d;
            fault     <= fault_d;
            done_q    <= pulse_d;
            alarm_q   <= (state_d == DONE);
            act       <= act_d;
        end
    end

    assign bus.phase      = state;
    assign bus.remain     = remain;
    assign bus.busy       = act.busy;
    assign bus.lock       = act.lock;
    assign bus.valve_in   = act.valve_in;
    assign bus.valve_out  = act.valve_out;
    assign bus.motor      = act.motor;
    assign bus.fault      = fault;
    assign bus.done_pulse = done_q;
    assign bus.alarm      = alarm_q;
endmodule
